// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (radix-2 shift-add multiply, restoring divide).
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC and go straight to FIN.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     mb_q, mb_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     rem_q, rem_d;
   logic                neg_q, neg_d;
   logic                a_neg_q, a_neg_d;
   logic [4:0]          cnt_q, cnt_d;
   logic                done_q, done_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_signed, b_signed, a_neg_in, b_neg_in, b_zero;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN:0]       mul_sum, div_shift, div_trial;
   logic                div_ge;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quot, remv;

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   logic div_ovf;
   assign div_ovf = op[2] & ~op[0] & (a == MIN_NEG) & (b == '1);
`endif

   always_comb begin
      a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_neg_in = a_signed & a[XLEN-1];
      b_neg_in = b_signed & b[XLEN-1];
      a_mag    = a_neg_in ? -a : a;
      b_mag    = b_neg_in ? -b : b;
      b_zero   = (b == '0);
   end

   // Per-cycle iteration step and the FIN sign fix-up, all on magnitudes.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
      div_shift = {rem_q, acc_q[XLEN-1]};
      div_trial = div_shift - {1'b0, mb_q};
      div_ge    = ~div_trial[XLEN];
      prod      = neg_q ? -acc_q : acc_q;
      quot      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      remv      = a_neg_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mb_d     = mb_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      a_neg_d  = a_neg_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op;
               a_neg_d = a_neg_in;
               cnt_d   = 5'd31;
               rem_d   = '0;
               state_d = CALC;
               if (op[2]) begin
                  // A zero divisor keeps the quotient positive so the all-ones result survives FIN.
                  neg_d = (a_neg_in ^ b_neg_in) & ~b_zero;
                  mb_d  = b_mag;
                  acc_d = {{XLEN{1'b0}}, a_mag};
               end else begin
                  neg_d = a_neg_in ^ b_neg_in;
                  mb_d  = a_mag;
                  acc_d = {{XLEN{1'b0}}, b_mag};
               end
`ifdef MULDIV_EARLY_OUT_EN
               if (op[2] && (b_zero || div_ovf)) begin
                  state_d = FIN;
                  acc_d   = {{XLEN{1'b0}}, (b_zero ? {XLEN{1'b1}} : MIN_NEG)};
                  rem_d   = b_zero ? a_mag : '0;
               end
`endif
            end
         end
         CALC: begin
            if (op_q[2]) begin
               acc_d = {acc_q[2*XLEN-2:0], div_ge};
               rem_d = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
            end else begin
               acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               state_d = FIN;
            end
         end
         FIN: begin
            case (op_q)
               3'b000:                 result_d = prod[XLEN-1:0];
               3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
               3'b100, 3'b101:         result_d = quot;
               default:                result_d = remv;
            endcase
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         op_q     <= '0;
         mb_q     <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mb_q     <= mb_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
         a_neg_q  <= a_neg_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
// Expected latency follows MULDIV_EARLY_OUT_EN when the bench is built with that macro.
module tb_muldiv_unit;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int numCompared;
   int numMismatched;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] refModel(input logic [2:0] fop, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, ux, uy;
      logic [63:0] r;
      logic ovf;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = longint'({32'b0, x});
      uy  = longint'({32'b0, y});
      ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
      case (fop)
         3'd0: begin r = ux * uy; return r[31:0]; end
         3'd1: begin r = sx * sy; return r[63:32]; end
         3'd2: begin r = sx * uy; return r[63:32]; end
         3'd3: begin r = ux * uy; return r[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFFFFFF;
            if (ovf) return 32'h80000000;
            r = sx / sy; return r[31:0];
         end
         3'd5: begin
            if (y == 0) return 32'hFFFFFFFF;
            r = ux / uy; return r[31:0];
         end
         3'd6: begin
            if (y == 0) return x;
            if (ovf) return 32'h0;
            r = sx % sy; return r[31:0];
         end
         default: begin
            if (y == 0) return x;
            r = ux % uy; return r[31:0];
         end
      endcase
   endfunction

   function automatic int expLatency(input logic [2:0] fop, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
      if (fop[2] && ((y == 0) || (!fop[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 2;
`endif
      return 34;
   endfunction

   // Waits (bounded) for done, sampling #1 after each rising edge
   task automatic waitDone(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Issue one op, scramble inputs after acceptance, check result, latency and the single-cycle done pulse
   task automatic applyStimulus(input string tag, input logic [2:0] fop, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] expected);
      int n;
      logic [31:0] held;
      @(negedge clk);
      start = 1'b1;
      op    = fop;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
      checkOutput({tag, "/busy"}, 64'(busy), 64'd1);
      waitDone(n);
      checkOutput({tag, "/latency"}, 64'(n + 1), 64'(expLatency(fop, x, y)));
      checkOutput({tag, "/result"}, 64'(result), 64'(expected));
      checkOutput({tag, "/busyDone"}, 64'(busy), 64'd0);
      held = result;
      @(posedge clk);
      #1;
      checkOutput({tag, "/donePulse"}, 64'(done), 64'd0);
      checkOutput({tag, "/hold"}, 64'(result), 64'(held));
   endtask

   initial begin
      int n;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      numCompared   = 0;
      numMismatched = 0;
      rstn  = 1'b0;
      start = 1'b0;
      op    = 3'd0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset/busy", 64'(busy), 64'd0);
      checkOutput("reset/done", 64'(done), 64'd0);
      checkOutput("reset/result", 64'(result), 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Reset in the middle of a multiply
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      checkOutput("midReset/busy", 64'(busy), 64'd0);
      checkOutput("midReset/done", 64'(done), 64'd0);
      checkOutput("midReset/result", 64'(result), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus("afterReset", 3'd0, 32'd1234, 32'd5678, 32'd7006652);

      applyStimulus("MUL", 3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA);
      applyStimulus("MULH", 3'd1, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF);
      applyStimulus("MULHU", 3'd3, 32'hFFFFFFFE, 32'h3, 32'h00000002);
      applyStimulus("MULHSU", 3'd2, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF);
      applyStimulus("DIV", 3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
      applyStimulus("REM", 3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
      applyStimulus("DIVU", 3'd5, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC);
      applyStimulus("REMU", 3'd7, 32'hFFFFFFF9, 32'h2, 32'h00000001);
      applyStimulus("DIV0", 3'd4, 32'h12345678, 32'h0, 32'hFFFFFFFF);
      applyStimulus("DIVU0", 3'd5, 32'h12345678, 32'h0, 32'hFFFFFFFF);
      applyStimulus("REM0", 3'd6, 32'h12345678, 32'h0, 32'h12345678);
      applyStimulus("REMU0", 3'd7, 32'h12345678, 32'h0, 32'h12345678);
      applyStimulus("DIV0neg", 3'd4, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF);
      applyStimulus("DIVovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      applyStimulus("REMovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

      // Start pulsed during CALC must be ignored; previous REMovf result (0) stays visible
      @(negedge clk);
      start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("ignored/resultHeld", 64'(result), 64'd0);
      checkOutput("ignored/busy", 64'(busy), 64'd1);
      waitDone(n);
      checkOutput("ignored/latency", 64'(n + 7), 64'd34);
      checkOutput("ignored/result", 64'(result), 64'd14);

      // Back-to-back: issue MUL 6*7 in the done cycle
      start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b/busy", 64'(busy), 64'd1);
      waitDone(n);
      checkOutput("b2b/latency", 64'(n + 1), 64'd34);
      checkOutput("b2b/result", 64'(result), 64'd42);
      @(posedge clk);
      #1;
      checkOutput("b2b/noQueue", 64'(busy), 64'd0);

      // Randomized ops, biased toward the divide corner cases
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 20));
            default: ;
         endcase
         applyStimulus($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, refModel(rop, ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
